// File: rtl/iir_cascade_scheduler.sv
// iir_cascade_scheduler
//
// Time-shares one biquad section engine across a cascade of SECTIONS IIR
// low-pass stages on the PDM microphone path. Each accepted input sample
// is walked through the stages in order. Every stage result becomes the
// operand of the next stage. The final cascade output is decimated by DECIM
// and presented on a valid/ready port. Coefficient-bank swaps are deferred to
// an idle cycle, so a swap never splits a sample across two banks.
//
// Optional build macro:
//   SECTION_BYPASS_EN  adds bypass_mask[SECTIONS-1:0]. A set bit skips that
//                      section: no engine request is made and the sample
//                      passes through that section unchanged.
//
// Ports:
//   pdm_clk, reset         clock; asynchronous active-high reset
//   in_valid/in_data       input sample, taken when in_valid & in_ready
//   in_ready               scheduler idle and able to take a sample
//   sec_start/sec_idx/sec_x  one-cycle request to the section engine
//   sec_y/sec_done         engine result and its one-cycle strobe
//   cfg_commit             request a coefficient-bank swap
//   coef_bank              active coefficient bank
//   bank_pending           swap requested but not yet applied
//   out_valid/out_data     decimated output, consumed by out_ready
//   overrun                sticky flag; an unread output was overwritten
//   bypass_mask            per-section skip mask (SECTION_BYPASS_EN only)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a sample; pending bank swaps are applied here
// S_ISSUE | sec_start pulse for section sec_idx (or a skip cycle)
// S_WAIT  | request outstanding; waiting for sec_done
// S_DECIM | cascade finished; step decimator, maybe load output

module iir_cascade_scheduler #(
    parameter int SECTIONS = 7,
    parameter int IDX_W    = 3,
    parameter int DATA_W   = 32,
    parameter int DECIM    = 64
) (
    input  logic              pdm_clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sec_start,
    output logic [IDX_W-1:0]  sec_idx,
    output logic [DATA_W-1:0] sec_x,
    input  logic [DATA_W-1:0] sec_y,
    input  logic              sec_done,
    input  logic              cfg_commit,
    output logic              coef_bank,
    output logic              bank_pending,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              overrun
`ifdef SECTION_BYPASS_EN
    ,
    input  logic [SECTIONS-1:0] bypass_mask
`endif
);

    localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECTIONS - 1);
    localparam logic [DEC_W-1:0] LAST_DEC = DEC_W'(DECIM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DECIM
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] work;
    logic [DEC_W-1:0]  dec_cnt;
    logic [IDX_W-1:0]  idx_next;
    logic              skip_first;
    logic              skip_next;

    assign idx_next = sec_idx + 1'b1;

    // The skip decision is taken on the edge that enters S_ISSUE. That edge
    // loads sec_start, so a skipped section never shows a request pulse.
    // skip_next is only consulted when sec_idx is below the last index.
`ifdef SECTION_BYPASS_EN
    assign skip_first = bypass_mask[0];
    assign skip_next  = bypass_mask[idx_next];
`else
    assign skip_first = 1'b0;
    assign skip_next  = 1'b0;
`endif

    always_ff @(posedge pdm_clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            in_ready     <= 1'b1;
            sec_start    <= 1'b0;
            sec_idx      <= '0;
            sec_x        <= '0;
            work         <= '0;
            dec_cnt      <= '0;
            coef_bank    <= 1'b0;
            bank_pending <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            overrun      <= 1'b0;
        end else begin
            // These are defaults. S_IDLE and S_DECIM below override them.
            if (cfg_commit) begin
                bank_pending <= 1'b1;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (bank_pending) begin
                        coef_bank    <= ~coef_bank;
                        // A commit in the swap cycle itself queues another swap.
                        bank_pending <= cfg_commit;
                    end
                    if (in_valid) begin
                        work      <= in_data;
                        sec_x     <= in_data;
                        sec_idx   <= '0;
                        sec_start <= ~skip_first;
                        in_ready  <= 1'b0;
                        state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    sec_start <= 1'b0;
                    if (sec_start) begin
                        state <= S_WAIT;
                    end else if (sec_idx == LAST_IDX) begin
                        state <= S_DECIM;
                    end else begin
                        sec_idx   <= idx_next;
                        sec_start <= ~skip_next;
                    end
                end

                S_WAIT: begin
                    if (sec_done) begin
                        work <= sec_y;
                        if (sec_idx == LAST_IDX) begin
                            state <= S_DECIM;
                        end else begin
                            sec_idx   <= idx_next;
                            sec_x     <= sec_y;
                            sec_start <= ~skip_next;
                            state     <= S_ISSUE;
                        end
                    end
                end

                S_DECIM: begin
                    if (dec_cnt == LAST_DEC) begin
                        dec_cnt   <= '0;
                        out_data  <= work;
                        out_valid <= 1'b1;
                        // If this cycle also consumes the old word, nothing is lost.
                        if (out_valid && !out_ready) begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        dec_cnt <= dec_cnt + 1'b1;
                    end
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end

                default: begin
                    in_ready  <= 1'b1;
                    sec_start <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_cascade_scheduler.sv
// Self-checking bench for iir_cascade_scheduler (SECTIONS=7, DECIM=4).
// The engine model returns y = x + 1. It raises sec_done two cycles after
// sec_start. The reference model predicts each sample's request list and
// output from the bypass mask. It also tracks decimation and the output
// handshake.
module tb_iir_cascade_scheduler;

    localparam int SECTIONS = 7;
    localparam int IDX_W    = 3;
    localparam int DATA_W   = 32;
    localparam int DECIM    = 4;

    logic              pdm_clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              sec_start;
    logic [IDX_W-1:0]  sec_idx;
    logic [DATA_W-1:0] sec_x;
    logic [DATA_W-1:0] sec_y;
    logic              sec_done;
    logic              cfg_commit = 1'b0;
    logic              coef_bank;
    logic              bank_pending;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;
    logic              overrun;
`ifdef SECTION_BYPASS_EN
    logic [SECTIONS-1:0] bypass_mask = '0;
`endif

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [SECTIONS-1:0] cur_mask = '0;
    int                  m_cnt = 0;
    bit                  m_valid = 0;
    logic [DATA_W-1:0]   m_data = '0;
    bit                  m_ovr = 0;
    bit                  m_bank = 0;

    iir_cascade_scheduler #(
        .SECTIONS(SECTIONS),
        .IDX_W(IDX_W),
        .DATA_W(DATA_W),
        .DECIM(DECIM)
    ) dut (
        .pdm_clk(pdm_clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .sec_start(sec_start),
        .sec_idx(sec_idx),
        .sec_x(sec_x),
        .sec_y(sec_y),
        .sec_done(sec_done),
        .cfg_commit(cfg_commit),
        .coef_bank(coef_bank),
        .bank_pending(bank_pending),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .overrun(overrun)
`ifdef SECTION_BYPASS_EN
        ,
        .bypass_mask(bypass_mask)
`endif
    );

    always #5 pdm_clk = ~pdm_clk;

    // section engine model
    int                eng_cnt = 0;
    logic [DATA_W-1:0] eng_x = '0;
    logic [DATA_W-1:0] eng_y = '0;
    logic              eng_done = 1'b0;
    logic              stray_done = 1'b0;
    assign sec_done = eng_done | stray_done;
    assign sec_y    = eng_y;

    always @(negedge pdm_clk or posedge reset) begin
        if (reset) begin
            eng_cnt  = 0;
            eng_done = 1'b0;
        end else begin
            eng_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0) begin
                    eng_done = 1'b1;
                    eng_y    = eng_x + 32'd1;
                end
            end
            if (sec_start) begin
                eng_cnt = 2;
                eng_x   = sec_x;
            end
        end
    end

    // request monitor
    int                iss_idx_q[$];
    logic [DATA_W-1:0] iss_x_q[$];
    always @(negedge pdm_clk) begin
        if (!reset && sec_start) begin
            iss_idx_q.push_back(int'(sec_idx));
            iss_x_q.push_back(sec_x);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_sec_start"}, sec_start, 0);
        chk({tag, "_sec_idx"}, sec_idx, 0);
        chk({tag, "_sec_x"}, sec_x, 0);
        chk({tag, "_coef_bank"}, coef_bank, 0);
        chk({tag, "_bank_pending"}, bank_pending, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge pdm_clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        chk("ready_timeout", ok, 1);
    endtask

    task automatic set_ready(input bit r);
        out_ready = r;
        @(negedge pdm_clk);
        if (r) m_valid = 0;
        chk("ready_out_valid", out_valid, m_valid);
        chk("ready_overrun", overrun, m_ovr);
    endtask

    task automatic set_mask(input logic [SECTIONS-1:0] m);
`ifdef SECTION_BYPASS_EN
        bypass_mask = m;
        cur_mask    = m;
`else
        cur_mask = '0;
        if (m != '0) $display("note: bypass mask ignored in this build");
`endif
    endtask

    task automatic send_sample(input logic [DATA_W-1:0] x, input bit drop_pulse, input bit commit3);
        int                j;
        bit                found;
        logic [DATA_W-1:0] e;
        wait_ready();
        iss_idx_q.delete();
        iss_x_q.delete();
        in_valid = 1'b1;
        in_data  = x;
        @(negedge pdm_clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        if (out_ready) m_valid = 0;
        if (drop_pulse) begin
            @(negedge pdm_clk);
            chk("drop_busy", in_ready, 0);
            in_valid = 1'b1;
            in_data  = ~x;
            @(negedge pdm_clk);
            in_valid = 1'b0;
        end
        if (commit3) begin
            found = 0;
            for (int i = 0; i < 100; i++) begin
                if (sec_start && sec_idx == 3'd3) begin
                    found = 1;
                    break;
                end
                @(negedge pdm_clk);
            end
            chk("commit_reach_idx3", found, 1);
            @(negedge pdm_clk);
            cfg_commit = 1'b1;
            @(negedge pdm_clk);
            cfg_commit = 1'b0;
            chk("commit_pending_wait", bank_pending, 1);
            chk("commit_bank_hold_wait", coef_bank, m_bank);
        end
        wait_ready();
        j = 0;
        for (int k = 0; k < SECTIONS; k++) begin
            if (!cur_mask[k]) begin
                if (j < iss_idx_q.size()) begin
                    e = x + 32'(j);
                    chk("issue_idx", iss_idx_q[j], k);
                    chk("issue_x", iss_x_q[j], e);
                end
                j++;
            end
        end
        chk("issue_count", iss_idx_q.size(), j);
        e = x + 32'(j);
        if (m_cnt == DECIM - 1) begin
            if (m_valid && !out_ready) m_ovr = 1;
            m_valid = 1;
            m_data  = e;
            m_cnt   = 0;
        end else begin
            m_cnt++;
        end
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("overrun", overrun, m_ovr);
        if (commit3) begin
            chk("commit_pending_idle", bank_pending, 1);
            chk("commit_bank_hold_idle", coef_bank, m_bank);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;

        // reset state
        reset = 1'b1;
        repeat (2) @(negedge pdm_clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        // four samples of 100, one output of 107 after the fourth
        set_ready(0);
        repeat (4) send_sample(32'd100, 0, 0);
        chk("t1_out_107", out_data, 32'd107);
        set_ready(1);

        // in_valid pulses while busy are dropped
        repeat (4) send_sample(32'd200, 1, 0);

        // commit mid-sample applies only on the next idle cycle
        send_sample(32'd300, 0, 1);
        m_bank = ~m_bank;
        @(negedge pdm_clk);
        chk("swap_bank", coef_bank, m_bank);
        chk("swap_cleared", bank_pending, 0);

        // commit landing on the swap cycle re-arms the pending flag
        cfg_commit = 1'b1;
        @(negedge pdm_clk);
        chk("rearm_pending", bank_pending, 1);
        chk("rearm_bank_before", coef_bank, m_bank);
        @(negedge pdm_clk);
        cfg_commit = 1'b0;
        m_bank = ~m_bank;
        chk("rearm_bank_swapped", coef_bank, m_bank);
        chk("rearm_pending_again", bank_pending, 1);
        @(negedge pdm_clk);
        m_bank = ~m_bank;
        chk("rearm_bank_second", coef_bank, m_bank);
        chk("rearm_pending_clear", bank_pending, 0);

        // consumer stalled over eight samples -> overrun, latest data kept
        set_ready(0);
        repeat (8) send_sample(32'd100, 0, 0);
        chk("t4_overrun", overrun, 1);
        chk("t4_latest", out_data, 32'd107);
        set_ready(1);
        chk("t4_overrun_sticky", overrun, 1);

        // reset while waiting on section 2, then a stray sec_done
        wait_ready();
        in_valid = 1'b1;
        in_data  = $urandom;
        @(negedge pdm_clk);
        in_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (sec_start && sec_idx == 3'd2) begin
                found = 1;
                break;
            end
            @(negedge pdm_clk);
        end
        chk("rst_reach_idx2", found, 1);
        @(negedge pdm_clk);
        chk("rst_busy", in_ready, 0);
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge pdm_clk);
        reset = 1'b0;
        stray_done = 1'b1;
        @(negedge pdm_clk);
        stray_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pdm_clk);
            chk("stray_no_start", sec_start, 0);
            chk("stray_idle", in_ready, 1);
        end
        m_cnt = 0; m_valid = 0; m_data = '0; m_ovr = 0; m_bank = 0;
        out_ready = 1'b0;
        iss_idx_q.delete();
        iss_x_q.delete();
        repeat (3) send_sample(32'd55, 0, 0);
        chk("post_rst_no_out", out_valid, 0);
        send_sample(32'd55, 0, 0);
        chk("post_rst_out", out_data, 32'd62);
        set_ready(1);

`ifdef SECTION_BYPASS_EN
        set_ready(0);
        set_mask(7'b0000101);
        repeat (DECIM) send_sample(32'd100, 0, 0);
        chk("bypass_out_105", out_data, 32'd105);
        set_mask(7'b1111111);
        repeat (DECIM) send_sample(32'd77, 0, 0);
        chk("bypass_all_out", out_data, 32'd77);
        set_ready(1);
        set_mask('0);
`endif

        // randomized samples, consumer readiness and drop pulses
        for (int s = 0; s < 24; s++) begin
            if ($urandom_range(0, 3) == 0) set_ready(1'($urandom_range(0, 1)));
`ifdef SECTION_BYPASS_EN
            set_mask(7'($urandom_range(0, 127)));
`endif
            send_sample($urandom, $urandom_range(0, 4) == 0, 0);
        end
        set_ready(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
